// File: rtl/out_port_fsm_pkg.sv
// Shared constants for the per-opcode instruction FSMs: opcodes, state encodings
// and the one-hot general-register output-enable codes.
package out_port_fsm_pkg;

  localparam logic [3:0] OPCODE_LDI_LO = 4'b0100;
  localparam logic [3:0] OPCODE_LDI_HI = 4'b0101;
  localparam logic [3:0] OPCODE_OUT    = 4'b0110;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PCINC = 3'd1,
    ST_READ  = 3'd2,
    ST_VALID = 3'd3,
    ST_DONE  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_R0   = 4'b1000;
  localparam logic [3:0] SEL_R1   = 4'b0100;
  localparam logic [3:0] SEL_R2   = 4'b0010;
  localparam logic [3:0] SEL_R3   = 4'b0001;

  function automatic logic [3:0] reg_onehot(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = SEL_R0;
      2'd1:    sel = SEL_R1;
      2'd2:    sel = SEL_R2;
      default: sel = SEL_R3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/out_port_fsm_reg_sel_decoder.sv
// Maps a 6-bit general-register index onto the one-hot output-enable lines;
// indices above R3 give no select and a cleared valid flag.
module reg_sel_decoder
  import out_port_fsm_pkg::*;
(
  input  logic [5:0] idx,
  output logic [3:0] onehot,
  output logic       valid
);

  assign valid  = (idx[5:2] == 4'd0);
  assign onehot = valid ? reg_onehot(idx[1:0]) : SEL_NONE;

endmodule

// File: rtl/out_port_fsm.sv
// OUT instruction FSM: enables one general register onto the bus, latches the
// value and offers it to the output port through a valid/ready handshake.
module out_port_fsm #(
  parameter logic [3:0]  OPCODE_OUT    = out_port_fsm_pkg::OPCODE_OUT,
  parameter int unsigned READY_TIMEOUT = 255,
  parameter int unsigned DATA_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instruction,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              port_ready,
  output logic [3:0]        rxOut,
  output logic              pcInc,
  output logic [DATA_W-1:0] port_data,
  output logic              port_valid,
  output logic              done,
  output logic              err
);
  import out_port_fsm_pkg::*;

  localparam int unsigned TMR_W = (READY_TIMEOUT == 0) ? 1 : $clog2(READY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(READY_TIMEOUT - 1);

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             err_flag;
  logic             op_hit;
  logic             sel_valid;
  logic [3:0]       sel_onehot;
  logic             timed_out;
  logic             unused_bits;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
    return (t == {TMR_W{1'b1}}) ? t : t + TMR_W'(1);
  endfunction

  assign op_hit      = (instruction[15:12] == OPCODE_OUT);
  assign timed_out   = (READY_TIMEOUT != 0) && (timer == TMR_LAST);
  assign unused_bits = &{1'b0, instruction[5:0]};

  reg_sel_decoder u_sel (
    .idx    (instruction[11:6]),
    .onehot (sel_onehot),
    .valid  (sel_valid)
  );

  // Outputs are assigned together with the state they belong to, so each is a
  // registered Moore output of the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rxOut      <= SEL_NONE;
      pcInc      <= 1'b0;
      port_valid <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_flag   <= 1'b0;
      timer      <= '0;
      port_data  <= '0;
    end else begin
      rxOut <= SEL_NONE;
      pcInc <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_hit) begin
            state <= ST_PCINC;
            pcInc <= 1'b1;
          end
        end
        ST_PCINC: begin
          if (!op_hit) begin
            state <= ST_IDLE;
          end else if (sel_valid) begin
            state <= ST_READ;
            rxOut <= sel_onehot;
          end else begin
            state    <= ST_DONE;
            err_flag <= 1'b1;
            done     <= 1'b1;
            err      <= 1'b1;
          end
        end
        ST_READ: begin
          if (!op_hit) begin
            state <= ST_IDLE;
          end else begin
            state      <= ST_VALID;
            port_valid <= 1'b1;
            port_data  <= bus_in;
            timer      <= '0;
          end
        end
        // The opcode is deliberately not consulted here: a started handshake always finishes.
        ST_VALID: begin
          if (port_ready || timed_out) begin
            state      <= ST_DONE;
            port_valid <= 1'b0;
            done       <= 1'b1;
            err        <= err_flag | ~port_ready;
            err_flag   <= err_flag | ~port_ready;
          end else begin
            timer <= sat_inc(timer);
          end
        end
        ST_DONE: begin
          state    <= op_hit ? ST_HOLD : ST_IDLE;
          err_flag <= 1'b0;
        end
        ST_HOLD: begin
          if (!op_hit) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_fsm.sv
// Scoreboard bench for out_port_fsm: a stimulus process issues OUT instructions and
// pushes the expected transaction outcome; a monitor assembles what the DUT did and compares.
module tb_out_port_fsm;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic [15:0] bus_in = 16'h0000;
  logic        port_ready = 1'b0;
  logic [3:0]  rxOut;
  logic        pcInc;
  logic [15:0] port_data;
  logic        port_valid;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  out_port_fsm #(.OPCODE_OUT(4'b0110), .READY_TIMEOUT(TO), .DATA_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .bus_in      (bus_in),
    .port_ready  (port_ready),
    .rxOut       (rxOut),
    .pcInc       (pcInc),
    .port_data   (port_data),
    .port_valid  (port_valid),
    .done        (done),
    .err         (err)
  );

  // kind: 0 completes with done, 1 aborted in READ, 2 reset during VALID
  typedef struct {
    int          kind;
    logic [3:0]  rx;
    int          rx_cycles;
    int          vcycles;
    logic [15:0] data;
    logic        err;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   flush = 1'b0;

  int          pc_cnt = 0, rx_cnt = 0, v_cnt = 0, unstable = 0;
  logic [3:0]  rx_seen = 4'h0;
  logic [15:0] vdata = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++)
      if (oh == (4'b1000 >> i)) return i;
    return 0;
  endfunction

  function automatic logic [3:0] other_op();
    logic [3:0] op;
    op = 4'($urandom);
    if (op == 4'h6) op = 4'h7;
    return op;
  endfunction

  task automatic clear_acc();
    pc_cnt = 0; rx_cnt = 0; v_cnt = 0; unstable = 0; rx_seen = 4'h0; vdata = 16'h0;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].kind == 2) void'(q.pop_front());
      clear_acc();
    end else begin
      if (flush) begin
        chk("abort_pending", (q.size() > 0) ? q[0].kind : -1, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("abort_pcinc_count", pc_cnt, 1);
          chk("abort_rxout", rx_seen, e.rx);
          chk("abort_rx_cycles", rx_cnt, e.rx_cycles);
          chk("abort_valid_cycles", v_cnt, 0);
        end
        clear_acc();
      end
      if (q.size() == 0) begin
        chk("idle_pcinc", pcInc, 0);
        chk("idle_done", done, 0);
      end
      if (!done) chk("err_without_done", err, 0);
      if (pcInc) pc_cnt++;
      if (rxOut != 4'h0) begin
        rx_seen = rxOut;
        rx_cnt++;
      end
      if (port_valid) begin
        v_cnt++;
        if (v_cnt == 1) vdata = port_data;
        else if (port_data !== vdata) unstable++;
      end
      if (done && q.size() > 0) begin
        e = q.pop_front();
        chk("done_kind", e.kind, 0);
        chk("pcinc_count", pc_cnt, 1);
        chk("rxout_select", rx_seen, e.rx);
        chk("rx_cycles", rx_cnt, e.rx_cycles);
        chk("valid_cycles", v_cnt, e.vcycles);
        chk("err", err, e.err);
        chk("done_latency", cyc - e.start, e.lat);
        chk("port_valid_at_done", port_valid, 0);
        if (e.vcycles > 0) begin
          chk("port_data", vdata, e.data);
          chk("port_data_stable", unstable, 0);
          chk("port_data_kept", port_data, e.data);
        end
        clear_acc();
      end
    end
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instruction = {other_op(), 12'($urandom)};
      bus_in = 16'($urandom);
      port_ready = 1'($urandom);
    end
  endtask

  // kind: 0 normal, 1 abort in READ, 2 reset in VALID, 3 opcode change in VALID
  task automatic run_txn(input logic [5:0] p1, input int d, input int kind, input logic [15:0] dval);
    logic [15:0] regs[4];
    exp_t e;
    bit   bad, fin;
    int   vcnt;
    for (int i = 0; i < 4; i++) regs[i] = 16'($urandom);
    regs[p1[1:0]] = dval;
    bad = (p1 > 6'd3);
    e.kind      = (kind == 3) ? 0 : kind;
    e.rx        = bad ? 4'h0 : (4'b1000 >> p1[1:0]);
    e.rx_cycles = bad ? 0 : 1;
    e.vcycles   = bad ? 0 : ((d + 1 < TO) ? d + 1 : TO);
    e.data      = regs[p1[1:0]];
    e.err       = bad || (d >= TO);
    e.lat       = bad ? 2 : 3 + e.vcycles;
    e.start     = cyc;
    q.push_back(e);
    instruction = {4'h6, p1, 6'($urandom)};
    vcnt = 0;
    fin = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(posedge clk); #1;
      bus_in = (rxOut != 4'h0) ? regs[oh_idx(rxOut)] : 16'($urandom);
      if (port_valid) begin
        port_ready = (vcnt >= d);
        vcnt++;
        if (kind == 3) instruction[15:12] = 4'h5;
        if (kind == 2 && vcnt == 3) begin
          rst = 1'b0;
          #1;
          chk("rst_port_valid", port_valid, 0);
          chk("rst_rxout", rxOut, 0);
          chk("rst_pcinc", pcInc, 0);
          chk("rst_done", done, 0);
          chk("rst_err", err, 0);
          chk("rst_port_data", port_data, 0);
          fin = 1'b1;
        end
      end else begin
        port_ready = 1'($urandom);
      end
      if (kind == 1 && rxOut != 4'h0) begin
        instruction[15:12] = 4'h5;
        fin = 1'b1;
      end
      if (done) fin = 1'b1;
    end
    chk("txn_finished", fin, 1);
    if (kind == 2) begin
      repeat (2) @(posedge clk);
      #1;
      instruction = {other_op(), 12'($urandom)};
      rst = 1'b1;
      idle_cycles(3);
    end else if (kind == 1) begin
      idle_cycles(3);
      @(posedge clk); #1; flush = 1'b1;
      @(posedge clk); #1; flush = 1'b0;
      idle_cycles(1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        bus_in = 16'($urandom);
        port_ready = 1'($urandom);
      end
      idle_cycles(2);
    end
  endtask

  initial begin
    logic [5:0] p1;
    int         kind;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rxout", rxOut, 0);
    chk("reset_pcinc", pcInc, 0);
    chk("reset_port_valid", port_valid, 0);
    chk("reset_port_data", port_data, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    instruction = 16'h5040;
    rst = 1'b1;
    idle_cycles(4);

    run_txn(6'd1, 0, 0, 16'hBEEF);
    run_txn(6'd1, 5, 0, 16'hBEEF);
    run_txn(6'd4, 0, 0, 16'h1234);
    run_txn(6'd2, 20, 0, 16'hA5A5);
    run_txn(6'd0, TO - 1, 0, 16'h0F0F);
    run_txn(6'd3, TO, 0, 16'hFFFF);
    run_txn(6'd3, 0, 1, 16'h5555);
    run_txn(6'd1, 3, 3, 16'hCAFE);
    run_txn(6'd2, 30, 2, 16'h7777);
    run_txn(6'd0, 0, 0, 16'h0000);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 4) == 0) p1 = 6'($urandom_range(4, 63));
      else p1 = 6'($urandom_range(0, 3));
      kind = 0;
      if (p1 <= 6'd3) begin
        case ($urandom_range(0, 9))
          0: kind = 1;
          1: kind = 3;
          2: kind = 2;
          default: kind = 0;
        endcase
      end
      run_txn(p1, $urandom_range(0, TO + 2), (kind == 2) ? 2 : kind, 16'($urandom));
    end

    idle_cycles(4);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
